// File: rtl/minibus_arbiter.sv
// Round-robin arbiter: N minibus masters share one slave, one whole transaction at a time.
// Grant registered one cycle after request; s_req/m_res combinational; slave stalls via ready, watchdog forces completion.
package minibus_arbiter_pkg;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } minibus_req_pack;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
  } minibus_res_pack;

endpackage

module minibus_arbiter
  import minibus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  minibus_req_pack        m_req [NUM_MASTERS],
  output minibus_res_pack        m_res [NUM_MASTERS],
  output minibus_req_pack        s_req,
  input  minibus_res_pack        s_res,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   timeout_err,
  output logic [IDX_W-1:0]       timeout_id
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(NUM_MASTERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);
  localparam minibus_res_pack  TMO_RES  = '{rdata: 32'h0, ready: 1'b1};

  // GAP is the mandatory idle cycle after every transaction; no arbitration happens in it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;
  logic                   tmo_err_q, tmo_err_d;
  logic [IDX_W-1:0]       tmo_id_q, tmo_id_d;

  logic [NUM_MASTERS-1:0]   req_any;
  logic [2*NUM_MASTERS-1:0] req_dbl;
  logic [NUM_MASTERS-1:0]   req_rot;
  logic [IDX_W-1:0]         win_off;
  logic [IDX_W:0]           win_sum;
  logic [IDX_W-1:0]         win_idx;
  logic [IDX_W-1:0]         win_nxt;
  logic                     win_vld;

  minibus_req_pack own_req;
  logic            own_act;
  logic            busy;
  logic            wd_hit;
  logic            expire;
  logic            done;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      req_any[i] = m_req[i].ren | m_req[i].wen;
    end
  end

  // Rotate requests so bit 0 is rr_ptr, pick the lowest set bit, then rotate back.
  assign req_dbl = {req_any, req_any};
  assign req_rot = req_dbl[rr_ptr_q +: NUM_MASTERS];
  assign win_vld = |req_rot;

  always_comb begin
    win_off = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_off = IDX_W'(i);
      end
    end
    win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
    win_idx = (win_sum >= N_EXT) ? IDX_W'(win_sum - N_EXT) : win_sum[IDX_W-1:0];
    win_nxt = (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);
  end

  assign busy    = (state_q == ST_BUSY);
  assign own_req = m_req[owner_q];
  assign own_act = own_req.ren | own_req.wen;
  assign wd_hit  = (TIMEOUT_CYCLES > 0) && (wd_cnt_q == WD_LAST);
  assign expire  = busy && wd_hit && !s_res.ready;
  assign done    = busy && (s_res.ready || !own_act || wd_hit);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      wd_cnt_q  <= '0;
      tmo_err_q <= 1'b0;
      tmo_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      wd_cnt_q  <= wd_cnt_d;
      tmo_err_q <= tmo_err_d;
      tmo_id_q  <= tmo_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    wd_cnt_d  = wd_cnt_q;
    tmo_err_d = expire;
    tmo_id_d  = expire ? owner_q : tmo_id_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d  = ST_BUSY;
          owner_d  = win_idx;
          rr_ptr_d = win_nxt;
          grant_d  = NUM_MASTERS'(1) << win_idx;
          wd_cnt_d = '0;
        end
      end
      ST_BUSY: begin
        if (done) begin
          state_d = ST_GAP;
          grant_d = '0;
        end else if (TIMEOUT_CYCLES > 0) begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // An aborting or expiring owner must not leak a half-formed request to the slave.
  always_comb begin
    s_req = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_res[i] = '0;
    end
    if (busy) begin
      if (own_act && !expire) begin
        s_req = own_req;
      end
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (owner_q == IDX_W'(i)) begin
          m_res[i] = expire ? TMO_RES : s_res;
        end
      end
    end
  end

  assign grant       = grant_q;
  assign timeout_err = tmo_err_q;
  assign timeout_id  = tmo_id_q;

endmodule

// File: tb/tb_minibus_arbiter.sv
// Bench for minibus_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_minibus_arbiter;
  import minibus_arbiter_pkg::*;

  localparam int N = 4;
  localparam int T = 4;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  minibus_req_pack m_req [N];
  minibus_res_pack m_res [N];
  minibus_req_pack s_req;
  minibus_res_pack s_res;
  logic [N-1:0]    grant;
  logic            timeout_err;
  logic [1:0]      timeout_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  minibus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .nrst(nrst), .m_req(m_req), .m_res(m_res), .s_req(s_req),
    .s_res(s_res), .grant(grant), .timeout_err(timeout_err), .timeout_id(timeout_id)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: owner (-1 = idle), rr pointer, busy-cycle count, post-transaction gap.
  int         mo = -1;
  int         mrr = 0;
  int         mcnt = 0;
  bit         mgap = 1'b0;
  bit         merr = 1'b0;
  logic [1:0] mid = 2'd0;

  always @(negedge clk) begin : model
    minibus_req_pack e_sreq;
    minibus_res_pack e_res [N];
    logic [N-1:0]    e_grant;
    bit              act, expire, done, found;
    int              j;
    if (!nrst) begin
      mo = -1; mrr = 0; mcnt = 0; mgap = 1'b0; merr = 1'b0; mid = 2'd0;
    end
    e_grant = (mo >= 0) ? (N'(1) << mo) : '0;
    e_sreq  = '0;
    for (int i = 0; i < N; i++) e_res[i] = '0;
    expire = 1'b0;
    done   = 1'b0;
    if (mo >= 0) begin
      act    = m_req[mo].ren | m_req[mo].wen;
      expire = !s_res.ready && (mcnt == T - 1);
      if (act && !expire) e_sreq = m_req[mo];
      e_res[mo] = expire ? minibus_res_pack'{rdata: 32'h0, ready: 1'b1} : s_res;
      done = s_res.ready || !act || expire;
    end
    chk("model_grant", 128'(grant), 128'(e_grant));
    chk("model_s_req", 128'(s_req), 128'(e_sreq));
    for (int i = 0; i < N; i++) chk("model_m_res", 128'(m_res[i]), 128'(e_res[i]));
    chk("model_timeout_err", 128'(timeout_err), 128'(merr));
    chk("model_timeout_id", 128'(timeout_id), 128'(mid));
    if (nrst) begin
      merr = expire;
      if (expire) mid = 2'(mo);
      if (mo >= 0) begin
        if (done) begin
          mo = -1;
          mgap = 1'b1;
        end else begin
          mcnt++;
        end
      end else if (mgap) begin
        mgap = 1'b0;
      end else begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          j = (mrr + k) % N;
          if (!found && (m_req[j].ren || m_req[j].wen)) begin
            found = 1'b1;
            mo    = j;
            mrr   = (j + 1) % N;
            mcnt  = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) m_req[i] = '0;
    s_res = '0;
  endtask

  // Leaves the caller at the start of a cycle with reset released.
  task automatic do_reset();
    nrst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  task automatic next_grant(input string nm, input logic [N-1:0] exp);
    int n = 0;
    @(negedge clk);
    while (grant == '0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 128'(grant), 128'(exp));
    while (grant != '0 && n < 24) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    minibus_req_pack rd;
    minibus_req_pack wr;
    logic [N-1:0]    rr_exp [6];
    logic [N-1:0]    gseq [$];
    int              rcyc [$];
    bit              act [N];
    bit              rdy_seen [N];
    int              r;

    clear_inputs();
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    // Reset idle
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("reset_grant", 128'(grant), 128'(0));
      chk("reset_s_req_rw", 128'({s_req.ren, s_req.wen}), 128'(0));
      for (int i = 0; i < N; i++) chk("reset_m_res_ready", 128'(m_res[i].ready), 128'(0));
    end

    // Single master: master 1 reads 0x40, slave answers on the third busy cycle
    do_reset();
    rd = '{ren: 1'b1, wen: 1'b0, addr: 32'h40, wdata: 32'h0, wstrb: 4'h0};
    m_req[1] = rd;
    @(negedge clk);
    chk("single_grant_c0", 128'(grant), 128'(0));
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) s_res = '{rdata: 32'h1234, ready: 1'b1};
      @(negedge clk);
      chk("single_grant", 128'(grant), 128'(4'b0010));
      chk("single_s_req", 128'(s_req), 128'(rd));
      chk("single_m_res0", 128'(m_res[0]), 128'(0));
      if (c < 3) chk("single_wait_ready", 128'(m_res[1].ready), 128'(0));
      else chk("single_m_res1", 128'(m_res[1]), 128'({32'h1234, 1'b1}));
    end
    tick();
    clear_inputs();
    @(negedge clk);
    chk("single_grant_after", 128'(grant), 128'(0));

    // Round-robin fairness with zero-wait slave
    do_reset();
    for (int i = 0; i < N; i++) m_req[i] = '{ren: 1'b1, wen: 1'b0, addr: 32'(i * 16), wdata: 32'h0, wstrb: 4'h0};
    s_res = '{rdata: 32'hA5, ready: 1'b1};
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (grant != '0) gseq.push_back(grant);
      for (int i = 0; i < N; i++) if (m_res[i].ready) rcyc.push_back(c);
      tick();
    end
    for (int k = 0; k < 6; k++)
      chk("rr_grant_order", 128'((gseq.size() > k) ? gseq[k] : 4'b0), 128'(rr_exp[k]));
    for (int k = 1; k < 6; k++)
      chk("rr_ready_spacing", 128'((rcyc.size() > k) ? rcyc[k] - rcyc[k-1] : 0), 128'(3));
    clear_inputs();

    // Contention right after reset, then rr pointer wraps back to 0
    do_reset();
    s_res = '{rdata: 32'h77, ready: 1'b1};
    m_req[2] = '{ren: 1'b1, wen: 1'b0, addr: 32'h200, wdata: 32'h0, wstrb: 4'h0};
    m_req[3] = '{ren: 1'b1, wen: 1'b0, addr: 32'h300, wdata: 32'h0, wstrb: 4'h0};
    next_grant("cont_first", 4'b0100);
    next_grant("cont_second", 4'b1000);
    tick();
    m_req[0] = '{ren: 1'b1, wen: 1'b0, addr: 32'h0, wdata: 32'h0, wstrb: 4'h0};
    next_grant("cont_rr_wrap", 4'b0001);
    clear_inputs();

    // Watchdog: slave never answers a write from master 0
    do_reset();
    s_res = '{rdata: 32'hDEADBEEF, ready: 1'b0};
    wr = '{ren: 1'b0, wen: 1'b1, addr: 32'h10, wdata: 32'hCAFE, wstrb: 4'hF};
    m_req[0] = wr;
    for (int c = 1; c <= 4; c++) begin
      tick();
      @(negedge clk);
      chk("wd_grant", 128'(grant), 128'(4'b0001));
      chk("wd_err_low", 128'(timeout_err), 128'(0));
      if (c < 4) chk("wd_no_ready", 128'(m_res[0].ready), 128'(0));
      else begin
        chk("wd_forced_res", 128'(m_res[0]), 128'({32'h0, 1'b1}));
        chk("wd_s_req_idle", 128'(s_req), 128'(0));
      end
    end
    tick();
    m_req[0] = '0;
    @(negedge clk);
    chk("wd_grant_after", 128'(grant), 128'(0));
    chk("wd_err_pulse", 128'(timeout_err), 128'(1));
    chk("wd_id", 128'(timeout_id), 128'(0));
    tick();
    @(negedge clk);
    chk("wd_err_one_cycle", 128'(timeout_err), 128'(0));

    // Abort: master 1 drops ren during a wait state
    do_reset();
    rd = '{ren: 1'b1, wen: 1'b0, addr: 32'h80, wdata: 32'h0, wstrb: 4'h0};
    m_req[1] = rd;
    tick();
    @(negedge clk);
    chk("abort_grant", 128'(grant), 128'(4'b0010));
    chk("abort_s_req_fwd", 128'(s_req), 128'(rd));
    tick();
    m_req[1].ren = 1'b0;
    @(negedge clk);
    chk("abort_s_req_idle", 128'(s_req), 128'(0));
    chk("abort_no_ready", 128'(m_res[1].ready), 128'(0));
    tick();
    @(negedge clk);
    chk("abort_grant_after", 128'(grant), 128'(0));

    // Asynchronous reset in the middle of a busy transaction
    do_reset();
    m_req[0] = '{ren: 1'b1, wen: 1'b0, addr: 32'h44, wdata: 32'h0, wstrb: 4'h0};
    tick();
    @(negedge clk);
    chk("mid_rst_busy", 128'(grant), 128'(4'b0001));
    @(posedge clk);
    #3;
    nrst = 1'b0;
    #1;
    chk("mid_rst_grant", 128'(grant), 128'(0));
    chk("mid_rst_s_req", 128'(s_req), 128'(0));
    chk("mid_rst_m_res", 128'(m_res[0]), 128'(0));
    clear_inputs();

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < N; i++) begin
      act[i] = 1'b0;
      rdy_seen[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc != 0) tick();
      if (!nrst) begin
        nrst = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        #2;
        nrst = 1'b0;
        for (int i = 0; i < N; i++) begin
          act[i] = 1'b0;
          m_req[i] = '0;
        end
      end
      if (nrst) begin
        for (int i = 0; i < N; i++) begin
          if (rdy_seen[i]) act[i] = 1'b0;
          if (act[i] && $urandom_range(0, 49) == 0) begin
            act[i] = 1'b0;
            m_req[i] = '0;
          end else if (!act[i]) begin
            m_req[i] = '0;
            if ($urandom_range(0, 2) == 0) begin
              act[i] = 1'b1;
              r = $urandom_range(1, 3);
              m_req[i] = '{ren: r[0], wen: r[1], addr: $urandom, wdata: $urandom, wstrb: 4'($urandom)};
            end
          end
        end
      end
      s_res = '{rdata: $urandom, ready: ($urandom_range(0, 99) < 35)};
      @(negedge clk);
      for (int i = 0; i < N; i++) rdy_seen[i] = m_res[i].ready;
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
